// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings and the arbitration rule for the two-port RAM arbiter.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // A lone requester always wins; a tie goes to the side holding priority.
  function automatic logic pick_winner(input logic a_req, input logic b_req,
                                       input logic prio);
    if (a_req && b_req) return prio;
    else if (b_req)     return OWNER_B;
    else                return OWNER_A;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// One requester's req/ack access channel into the shared RAM.
interface ram_port_arbiter_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  wdata;
  logic              ack;
  logic [WIDTH-1:0]  rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/ram_port_arbiter_ram_bank.sv
// Register-file storage: load-enabled words, combinational read.
module ram_bank #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Write the addressed word when load is set; contents survive reset.
  always_ff @(posedge clk) begin
    if (load) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
// Each access takes IDLE -> SERVE -> RESP, so acks arrive two cycles after
// the request is seen and accesses are spaced three cycles apart.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  ram_port_arbiter_if.slave  a,
  ram_port_arbiter_if.slave  b,
  output logic               busy,
  output logic               owner
);

  state_t            state;
  logic              prio;
  logic              owner_q;
  logic              busy_q;
  logic              a_ack_q, b_ack_q;
  logic [WIDTH-1:0]  a_rdata_q, b_rdata_q;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_wdata;
  logic [WIDTH-1:0]  ram_dout;
  logic              ram_load;

  assign sel_we    = (owner_q == OWNER_B) ? b.we    : a.we;
  assign sel_addr  = (owner_q == OWNER_B) ? b.addr  : a.addr;
  assign sel_wdata = (owner_q == OWNER_B) ? b.wdata : a.wdata;

  // A reset landing in SERVE must not let the pending write reach the array.
  assign ram_load = (state == ST_SERVE) && sel_we && !reset;

  ram_bank #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_bank (
    .clk  (clk),
    .load (ram_load),
    .addr (sel_addr),
    .din  (sel_wdata),
    .dout (ram_dout)
  );

  // Arbitration FSM with registered ack, rdata, owner and busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      prio      <= OWNER_A;
      owner_q   <= OWNER_A;
      busy_q    <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (a.req || b.req) begin
            owner_q <= pick_winner(a.req, b.req, prio);
            busy_q  <= 1'b1;
            state   <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          // Only reads refresh the requester's rdata register.
          if (!sel_we) begin
            if (owner_q == OWNER_B) b_rdata_q <= ram_dout;
            else                    a_rdata_q <= ram_dout;
          end
          if (owner_q == OWNER_B) b_ack_q <= 1'b1;
          else                    a_ack_q <= 1'b1;
          prio  <= ~owner_q;
          state <= ST_RESP;
        end
        ST_RESP: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Reset arriving during RESP kills the ack pulse immediately.
  assign a.ack   = a_ack_q && !reset;
  assign b.ack   = b_ack_q && !reset;
  assign a.rdata = a_rdata_q;
  assign b.rdata = b_rdata_q;
  assign busy    = busy_q;
  assign owner   = owner_q;

endmodule
